// File: rtl/pong_pkg.sv
// Shared types, colours and priority helper for the pong pixel pipeline.
package pong_pkg;

    typedef logic [11:0] bgr_t;

    localparam bgr_t COL_BALL  = 12'h3C0;
    localparam bgr_t COL_FLASH = 12'hFFF;
    localparam bgr_t COL_WALL  = 12'h00F;
    localparam bgr_t COL_PAD   = 12'hFFF;
    localparam bgr_t COL_NET   = 12'h888;
    localparam bgr_t COL_BG    = 12'h000;

    localparam int NET_X0 = 316;
    localparam int NET_X1 = 324;

    typedef enum logic {IDLE, FLASH} flash_state_t;

    // Fixed draw order: ball > wall > pad > netline > background.
    function automatic bgr_t pick_colour(input logic ball, input logic flash_on,
                                         input logic wall, input logic pad,
                                         input logic net);
        bgr_t colour;
        colour = COL_BG;
        if (ball)
            colour = flash_on ? COL_FLASH : COL_BALL;
        else if (wall)
            colour = COL_WALL;
        else if (pad)
            colour = COL_PAD;
        else if (net)
            colour = COL_NET;
        return colour;
    endfunction

endpackage

// File: rtl/pong_rect_hit.sv
// Combinational point-in-rectangle test; edges widened by one bit so the
// far edge of a rectangle near the top of the coordinate range never wraps.
module pong_rect_hit #(
    parameter int COORD_W = 10,
    parameter int RECT_W  = 8,
    parameter int RECT_H  = 8
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_rx,
    input  logic [COORD_W-1:0] i_ry,
    output logic               o_hit
);
    localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(RECT_W);
    localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(RECT_H);

    logic [COORD_W:0] w_x;
    logic [COORD_W:0] w_y;
    logic [COORD_W:0] w_rx;
    logic [COORD_W:0] w_ry;

    assign w_x  = {1'b0, i_x};
    assign w_y  = {1'b0, i_y};
    assign w_rx = {1'b0, i_rx};
    assign w_ry = {1'b0, i_ry};

    assign o_hit = (w_x >= w_rx) && (w_x < w_rx + W_EXT) &&
                   (w_y >= w_ry) && (w_y < w_ry + H_EXT);
endmodule

// File: rtl/pong_pixel_pipe.sv
// Two-stage pong pixel colourer with frame-start position snapshot and hit flash.
// Optional dashed centre net is built only when PONG_NET_EN is defined.
module pong_pixel_pipe
    import pong_pkg::*;
#(
    parameter int NUM_PADS     = 2,
    parameter int COORD_W      = 10,
    parameter int BALL_SZ      = 8,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 64,
    parameter int PAD0_X       = 28,
    parameter int PAD1_X       = 604,
    parameter int WALL_T       = 8,
    parameter int WALL_B       = 470,
    parameter int RWALL_X      = 631,
    parameter int FLASH_FRAMES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    input  logic [COORD_W-1:0]           pix_x,
    input  logic [COORD_W-1:0]           pix_y,
    input  logic                         frame_start,
    input  logic [COORD_W-1:0]           ball_x,
    input  logic [COORD_W-1:0]           ball_y,
    input  logic [NUM_PADS*COORD_W-1:0]  pad_y,
    input  logic                         hit_pulse,
    output logic                         bgr_valid,
    output bgr_t                         bgr
);
    localparam int                 FC_W       = $clog2(FLASH_FRAMES + 1);
    localparam logic [FC_W-1:0]    FLASH_LOAD = FC_W'(FLASH_FRAMES);
    localparam logic [COORD_W-1:0] WALL_T_C   = COORD_W'(WALL_T);
    localparam logic [COORD_W-1:0] WALL_B_C   = COORD_W'(WALL_B);

    logic [COORD_W-1:0]          r_ball_x;
    logic [COORD_W-1:0]          r_ball_y;
    logic [NUM_PADS*COORD_W-1:0] r_pad_y;
    logic [2:0]                  r_frame_cnt;
    flash_state_t                r_state;
    logic [FC_W-1:0]             r_flash_cnt;

    logic r_s1_valid, r_s1_ball, r_s1_flash, r_s1_wall, r_s1_pad, r_s1_net;
    logic r_bgr_valid;
    bgr_t r_bgr;

    logic                w_in_field;
    logic                w_ball;
    logic                w_wall;
    logic                w_pad;
    logic                w_net;
    logic                w_flash_on;
    logic [NUM_PADS-1:0] w_pad_rect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ball_x    <= '0;
            r_ball_y    <= '0;
            r_pad_y     <= '0;
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_ball_x    <= ball_x;
            r_ball_y    <= ball_y;
            r_pad_y     <= pad_y;
            r_frame_cnt <= r_frame_cnt + 3'd1;
        end
    end

    // A hit in the same cycle as frame_start reloads without decrementing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flash_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (hit_pulse) begin
                        r_state     <= FLASH;
                        r_flash_cnt <= FLASH_LOAD;
                    end
                end
                FLASH: begin
                    if (hit_pulse) begin
                        r_flash_cnt <= FLASH_LOAD;
                    end else if (frame_start) begin
                        r_flash_cnt <= r_flash_cnt - FC_W'(1);
                        if (r_flash_cnt == FC_W'(1))
                            r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_flash_cnt <= '0;
                end
            endcase
        end
    end

    assign w_flash_on = (r_state == FLASH) && r_frame_cnt[2];
    assign w_in_field = (pix_y >= WALL_T_C) && (pix_y <= WALL_B_C);

    pong_rect_hit #(
        .COORD_W (COORD_W),
        .RECT_W  (BALL_SZ),
        .RECT_H  (BALL_SZ)
    ) u_ball_hit (
        .i_x   (pix_x),
        .i_y   (pix_y),
        .i_rx  (r_ball_x),
        .i_ry  (r_ball_y),
        .o_hit (w_ball)
    );

    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : gen_pad
            localparam int PX = (gi == 0) ? PAD0_X : PAD1_X;
            pong_rect_hit #(
                .COORD_W (COORD_W),
                .RECT_W  (PAD_W),
                .RECT_H  (PAD_H)
            ) u_pad_hit (
                .i_x   (pix_x),
                .i_y   (pix_y),
                .i_rx  (COORD_W'(PX)),
                .i_ry  (r_pad_y[gi*COORD_W +: COORD_W]),
                .o_hit (w_pad_rect[gi])
            );
        end

        if (NUM_PADS == 1) begin : gen_wall_rwall
            localparam logic [COORD_W-1:0] RWALL_C = COORD_W'(RWALL_X);
            assign w_wall = (pix_y < WALL_T_C) || (pix_y > WALL_B_C) || (pix_x >= RWALL_C);
        end else begin : gen_wall_tb
            assign w_wall = (pix_y < WALL_T_C) || (pix_y > WALL_B_C);
        end
    endgenerate

    assign w_pad = (|w_pad_rect) && w_in_field;

`ifdef PONG_NET_EN
    localparam logic [COORD_W-1:0] NET_X0_C = COORD_W'(NET_X0);
    localparam logic [COORD_W-1:0] NET_X1_C = COORD_W'(NET_X1);
    // Dashes are 16 rows on, 16 rows off.
    assign w_net = (pix_x >= NET_X0_C) && (pix_x < NET_X1_C) && !pix_y[4] && w_in_field;
`else
    assign w_net = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ball  <= 1'b0;
            r_s1_flash <= 1'b0;
            r_s1_wall  <= 1'b0;
            r_s1_pad   <= 1'b0;
            r_s1_net   <= 1'b0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_ball  <= pix_valid && w_ball;
            r_s1_flash <= w_flash_on;
            r_s1_wall  <= pix_valid && w_wall;
            r_s1_pad   <= pix_valid && w_pad;
            r_s1_net   <= pix_valid && w_net;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bgr_valid <= 1'b0;
            r_bgr       <= COL_BG;
        end else begin
            r_bgr_valid <= r_s1_valid;
            r_bgr       <= r_s1_valid ? pick_colour(r_s1_ball, r_s1_flash, r_s1_wall,
                                                    r_s1_pad, r_s1_net)
                                      : COL_BG;
        end
    end

    assign bgr_valid = r_bgr_valid;
    assign bgr       = r_bgr;
endmodule
